pipe_stage_chain: RTL and testbench

- Parametrised chain of DEPTH pipeline registers, each WIDTH bits of payload plus a valid bit.
- Supports per-stage hold (stall) and per-stage flush, and inserts a bubble below any held stage.
- Replaces the fixed-width, clear-on-stall stage registers between F/D/E/M/W.
- Exposes stage contents for forwarding, hazard and exception logic.

---
 rtl/pipe_stage_chain_pkg.sv | 34 +++
 rtl/pipe_stage_chain_cell.sv | 71 +++++++
 rtl/pipe_stage_chain.sv | 113 +++++++++++
 tb/tb_pipe_stage_chain.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_chain_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_chain_pkg
// Brief    : Stage indices, bubble constant and cell action decode for the chain.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_stage_chain_pkg;

  localparam int STG_F = 0;
  localparam int STG_D = 1;
  localparam int STG_E = 2;
  localparam int STG_M = 3;
  localparam int STG_W = 4;

  localparam int   DEFAULT_WIDTH = 32;
  localparam logic BUBBLE_VALID  = 1'b0;

  typedef enum logic [1:0] {
    ACT_FLUSH  = 2'd0,
    ACT_KEEP   = 2'd1,
    ACT_BUBBLE = 2'd2,
    ACT_LOAD   = 2'd3
  } cell_act_e;

  function automatic cell_act_e sel_act(input logic flush, input logic keep,
                                        input logic bubble);
    if (flush)       return ACT_FLUSH;
    else if (keep)   return ACT_KEEP;
    else if (bubble) return ACT_BUBBLE;
    else             return ACT_LOAD;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_stage_chain_cell.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_cell
// Brief    : One valid+payload pipeline register with flush > keep > bubble > load.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_cell
  import pipe_stage_chain_pkg::*;
#(
  parameter int WIDTH        = DEFAULT_WIDTH,
  parameter bit ZERO_BUBBLE  = 1'b1,
  parameter bit GATE_INVALID = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_flush,
  input  logic             i_keep,
  input  logic             i_bubble,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_next_valid
);

  cell_act_e        w_act;
  logic             w_next_valid;
  logic [WIDTH-1:0] w_next_data;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  always_comb begin
    w_act        = sel_act(i_flush, i_keep, i_bubble);
    w_next_valid = r_valid;
    w_next_data  = r_data;
    case (w_act)
      ACT_FLUSH, ACT_BUBBLE: begin
        w_next_valid = BUBBLE_VALID;
        if (ZERO_BUBBLE) w_next_data = '0;
      end
      ACT_KEEP: begin
        w_next_valid = r_valid;
      end
      ACT_LOAD: begin
        w_next_valid = i_valid;
        // The input stage only captures payload alongside a valid item.
        if (!GATE_INVALID || i_valid) w_next_data = i_data;
        else if (ZERO_BUBBLE)         w_next_data = '0;
      end
      default: begin
        w_next_valid = r_valid;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= w_next_valid;
      r_data  <= w_next_data;
    end
  end

  assign o_valid      = r_valid;
  assign o_data       = r_data;
  assign o_next_valid = w_next_valid;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_chain.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_chain
// Brief    : DEPTH-stage hold/flush pipeline with occupancy and stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_chain
  import pipe_stage_chain_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int DEPTH       = 4,
  parameter bit ZERO_BUBBLE = 1'b1,
  parameter int CNT_W       = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_in_valid,
  input  logic [WIDTH-1:0]             i_in_data,
  input  logic [DEPTH-1:0]             i_hold,
  input  logic [DEPTH-1:0]             i_flush,
  output logic [DEPTH-1:0]             o_stage_valid,
  output logic [WIDTH*DEPTH-1:0]       o_stage_data,
  output logic                         o_out_valid,
  output logic [WIDTH-1:0]             o_out_data,
  output logic [$clog2(DEPTH+1)-1:0]   o_occupancy,
  output logic [CNT_W-1:0]             o_stall_cycles
);

  localparam int c_OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]       w_eh;
  logic [DEPTH-1:0]       w_valid;
  logic [DEPTH-1:0]       w_next_valid;
  logic [WIDTH*DEPTH-1:0] w_data;
  logic [c_OCC_W-1:0]     w_occ_next;
  logic [c_OCC_W-1:0]     r_occupancy;
  logic [CNT_W-1:0]       r_stall_cycles;

  // A hold anywhere downstream freezes every stage above it.
  for (genvar i = 0; i < DEPTH; i++) begin : g_eh
    if (i == DEPTH-1) begin : g_eh_last
      assign w_eh[i] = i_hold[i];
    end else begin : g_eh_mid
      assign w_eh[i] = i_hold[i] | w_eh[i+1];
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_first
      pipe_stage_cell #(
        .WIDTH        (WIDTH),
        .ZERO_BUBBLE  (ZERO_BUBBLE),
        .GATE_INVALID (1'b1)
      ) u_cell (
        .clk          (clk),
        .reset        (reset),
        .i_flush      (i_flush[i]),
        .i_keep       (w_eh[i]),
        .i_bubble     (1'b0),
        .i_valid      (i_in_valid),
        .i_data       (i_in_data),
        .o_valid      (w_valid[i]),
        .o_data       (w_data[i*WIDTH +: WIDTH]),
        .o_next_valid (w_next_valid[i])
      );
    end else begin : g_rest
      pipe_stage_cell #(
        .WIDTH        (WIDTH),
        .ZERO_BUBBLE  (ZERO_BUBBLE),
        .GATE_INVALID (1'b0)
      ) u_cell (
        .clk          (clk),
        .reset        (reset),
        .i_flush      (i_flush[i]),
        .i_keep       (w_eh[i]),
        .i_bubble     (w_eh[i-1]),
        .i_valid      (w_valid[i-1]),
        .i_data       (w_data[(i-1)*WIDTH +: WIDTH]),
        .o_valid      (w_valid[i]),
        .o_data       (w_data[i*WIDTH +: WIDTH]),
        .o_next_valid (w_next_valid[i])
      );
    end
  end

  always_comb begin
    w_occ_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_occ_next = w_occ_next + c_OCC_W'(w_next_valid[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_occupancy    <= '0;
      r_stall_cycles <= '0;
    end else begin
      r_occupancy <= w_occ_next;
      if (w_eh[0] && (r_stall_cycles != {CNT_W{1'b1}})) begin
        r_stall_cycles <= r_stall_cycles + 1'b1;
      end
    end
  end

  assign o_stage_valid  = w_valid;
  assign o_stage_data   = w_data;
  assign o_out_valid    = w_valid[DEPTH-1];
  assign o_out_data     = w_data[(DEPTH-1)*WIDTH +: WIDTH];
  assign o_occupancy    = r_occupancy;
  assign o_stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_chain.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_chain
// Brief    : Scoreboard bench for pipe_stage_chain, DEPTH=3, both bubble modes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_chain;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_in_valid;
  logic [31:0] i_in_data;
  logic [2:0]  i_hold;
  logic [2:0]  i_flush;

  logic [2:0]  a_sv,  b_sv;
  logic [95:0] a_sd,  b_sd;
  logic        a_ov,  b_ov;
  logic [31:0] a_od,  b_od;
  logic [1:0]  a_occ, b_occ;
  logic [3:0]  a_st,  b_st;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] q_a[$];
  logic [31:0] q_b[$];
  logic mon_en = 1'b0;
  logic kept_q = 1'b0;

  always #5 clk = ~clk;

  pipe_stage_chain #(.WIDTH(32), .DEPTH(3), .ZERO_BUBBLE(1'b1), .CNT_W(4)) dut_a (
    .clk(clk), .reset(reset), .i_in_valid(i_in_valid), .i_in_data(i_in_data),
    .i_hold(i_hold), .i_flush(i_flush), .o_stage_valid(a_sv), .o_stage_data(a_sd),
    .o_out_valid(a_ov), .o_out_data(a_od), .o_occupancy(a_occ), .o_stall_cycles(a_st));

  pipe_stage_chain #(.WIDTH(32), .DEPTH(3), .ZERO_BUBBLE(1'b0), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .i_in_valid(i_in_valid), .i_in_data(i_in_data),
    .i_hold(i_hold), .i_flush(i_flush), .o_stage_valid(b_sv), .o_stage_data(b_sd),
    .o_out_valid(b_ov), .o_out_data(b_od), .o_occupancy(b_occ), .o_stall_cycles(b_st));

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    q_a.push_back(d);
    q_b.push_back(d);
  endtask

  task automatic feed(input logic [31:0] d);
    i_in_valid = 1'b1;
    i_in_data  = d;
    step();
  endtask

  // An item held in the last stage is presented once, not once per cycle.
  always @(posedge clk) kept_q <= i_hold[2] & ~i_flush[2] & ~reset;

  always @(negedge clk) begin
    if (mon_en && a_ov && !kept_q) begin
      if (q_a.size() == 0) chk("mon_a_unexpected", a_od, 128'hDEAD);
      else chk("mon_a_data", a_od, q_a.pop_front());
    end
    if (mon_en && b_ov && !kept_q) begin
      if (q_b.size() == 0) chk("mon_b_unexpected", b_od, 128'hDEAD);
      else chk("mon_b_data", b_od, q_b.pop_front());
    end
  end

  initial begin
    reset = 1'b1; i_in_valid = 1'b0; i_in_data = '0; i_hold = '0; i_flush = '0;
    step(); step();
    chk("rst_valid_a", a_sv, 0);   chk("rst_data_a", a_sd, 0);
    chk("rst_occ_a", a_occ, 0);    chk("rst_stall_a", a_st, 0);
    chk("rst_valid_b", b_sv, 0);   chk("rst_data_b", b_sd, 0);
    reset = 1'b0;
    mon_en = 1'b1;

    // Streaming latency
    push(32'h11); push(32'h22); push(32'h33);
    feed(32'h11); feed(32'h22);
    chk("s1_out_not_yet", a_ov, 0);
    feed(32'h33);
    chk("s1_out_edge3_valid", a_ov, 1);
    chk("s1_out_edge3_data", a_od, 32'h11);
    chk("s1_occ_full", a_occ, 3);
    i_in_valid = 1'b0;
    step(); step(); step();
    chk("s1_occ_drained", a_occ, 0);

    // Hold on stage 1 bubbles stage 2
    push(32'hA1); push(32'hB2); push(32'hC3); push(32'hD4);
    feed(32'hA1); feed(32'hB2); feed(32'hC3);
    i_hold = 3'b010; i_in_valid = 1'b1; i_in_data = 32'hD4;
    for (int h = 1; h <= 2; h++) begin
      step();
      chk("s2_valid", a_sv, 3'b011);
      chk("s2_stage0_frozen", a_sd[31:0], 32'hC3);
      chk("s2_stage1_frozen", a_sd[63:32], 32'hB2);
      chk("s2_bubble_zero", a_sd[95:64], 0);
      chk("s2_zb0_bubble_valid", b_sv[2], 0);
      chk("s2_zb0_bubble_keep", b_sd[95:64], 32'hA1);
      chk("s2_stall_a", a_st, 4'(h));
    end
    i_hold = 3'b000;
    step();
    i_in_valid = 1'b0;
    step(); step(); step(); step();
    chk("s2_stall_after", a_st, 2);
    chk("s2_occ_drained", a_occ, 0);

    // Flush beats hold; held output stage keeps its item
    push(32'hE5);
    feed(32'hE5); feed(32'hF6); feed(32'h07);
    i_in_valid = 1'b0; i_flush = 3'b011; i_hold = 3'b110;
    step();
    chk("s3_valid", a_sv, 3'b100);
    chk("s3_low_zero", a_sd[63:0], 0);
    chk("s3_stage2_kept", a_sd[95:64], 32'hE5);
    chk("s3_occ", a_occ, 1);
    chk("s3_zb0_flushed_payload", b_sd[63:32], 32'hF6);
    chk("s3_stall", a_st, 3);
    i_flush = 3'b000; i_hold = 3'b000;
    step(); step(); step();

    // Downstream stage loads the flushed stage's pre-edge contents
    push(32'h31); push(32'h32);
    feed(32'h31); feed(32'h32);
    i_in_valid = 1'b0; i_flush = 3'b001;
    step();
    chk("s3b_valid", a_sv, 3'b110);
    chk("s3b_stage1", a_sd[63:32], 32'h32);
    chk("s3b_stage2", a_sd[95:64], 32'h31);
    i_flush = 3'b000;
    step(); step(); step();

    // Reset while full and fully held
    push(32'h41);
    feed(32'h41); feed(32'h42); feed(32'h43);
    i_in_valid = 1'b0; i_hold = 3'b111;
    step();
    chk("s4_full_held", a_sv, 3'b111);
    chk("s4_stall_pre", a_st, 4);
    reset = 1'b1;
    step();
    chk("s4_valid_a", a_sv, 0);  chk("s4_data_a", a_sd, 0);
    chk("s4_occ_a", a_occ, 0);   chk("s4_stall_a", a_st, 0);
    chk("s4_valid_b", b_sv, 0);  chk("s4_stall_b", b_st, 0);
    reset = 1'b0; i_hold = 3'b000;

    // Stall counter saturation at 15 (CNT_W=4)
    i_hold = 3'b001;
    for (int k = 1; k <= 21; k++) begin
      step();
      chk("s6_stall_a", a_st, (k < 15) ? 4'(k) : 4'd15);
      chk("s6_stall_b", b_st, (k < 15) ? 4'(k) : 4'd15);
    end
    i_hold = 3'b000;
    step(); step();
    chk("sb_queue_a_empty", q_a.size(), 0);
    chk("sb_queue_b_empty", q_b.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
